// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control unit: FSM states, instruction layout, flag bit indices.
package alu_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_WB   = 2'd2;

  // Instruction word layout, MSB first: FS, Rd, Ra, Rb, CinSel, CinLit.
  typedef struct packed {
    logic [4:0] fs;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       cin_sel;
    logic       cin_lit;
  } instr_t;

  // Flags are packed as {C, Z, N}.
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/alu_flag_reg.sv
// C/Z/N status register; loads Z/N on load, C only when c_load is also set.
// One-cycle update, no backpressure.
module alu_flag_reg
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        c_load,
  input  logic [15:0] f,
  input  logic        cout,
  output logic [2:0]  flags
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= 3'b000;
    end else if (load) begin
      flags[FLAG_Z] <= (f == 16'h0000);
      flags[FLAG_N] <= f[15];
      if (c_load) begin
        flags[FLAG_C] <= cout;
      end
    end
  end

endmodule

// File: rtl/alu_control_unit.sv
// Sequences one ALU instruction through IDLE -> EXEC -> WB; write-back one cycle after EXEC.
// Accepts a new instruction only in IDLE, so throughput is one per three cycles.
module alu_control_unit
  import alu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InstrValid,
  input  logic [15:0] Instr,
  output logic        InstrReady,
  input  logic [15:0] F,
  input  logic        Cout,
  output logic [4:0]  FS,
  output logic        Cin,
  output logic [2:0]  SelA,
  output logic [2:0]  SelB,
  output logic [2:0]  WrAddr,
  output logic        WrEn,
  output logic [2:0]  Flags,
  output logic [15:0] InstrCount
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  instr_t      ir;
  logic [15:0] instr_count;
  logic        accept;
  logic        flag_load;
  logic        flag_c_load;

  assign InstrReady = (state == ST_IDLE);
  assign accept     = InstrValid && InstrReady;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      ir          <= '0;
      instr_count <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ir <= instr_t'(Instr);
      end
      if (state == ST_WB) begin
        instr_count <= instr_count + 16'd1;
      end
    end
  end

  // Flags update at the end of EXEC, so Cin during EXEC sees the previous carry.
  assign flag_load   = (state == ST_EXEC);
  assign flag_c_load = flag_load && ir.fs[4];

  alu_flag_reg u_flag_reg (
    .clk    (Clock),
    .rst    (Reset),
    .load   (flag_load),
    .c_load (flag_c_load),
    .f      (F),
    .cout   (Cout),
    .flags  (Flags)
  );

  assign FS         = ir.fs;
  assign SelA       = ir.ra;
  assign SelB       = ir.rb;
  assign WrAddr     = ir.rd;
  assign Cin        = ir.cin_sel ? Flags[FLAG_C] : ir.cin_lit;
  assign WrEn       = (state == ST_WB);
  assign InstrCount = instr_count;

endmodule

// File: tb/tb_alu_control_unit.sv
// Closed-loop bench: register file and ALU around the DUT, instruction-level reference model
// feeding a scoreboard queue that a monitor drains on each WrEn pulse.
module tb_alu_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InstrValid;
  logic [15:0] Instr;
  logic        InstrReady;
  logic [15:0] F;
  logic        Cout;
  logic [4:0]  FS;
  logic        Cin;
  logic [2:0]  SelA, SelB, WrAddr;
  logic        WrEn;
  logic [2:0]  Flags;
  logic [15:0] InstrCount;

  alu_control_unit dut (
    .Clock(Clock), .Reset(Reset), .InstrValid(InstrValid), .Instr(Instr),
    .InstrReady(InstrReady), .F(F), .Cout(Cout), .FS(FS), .Cin(Cin),
    .SelA(SelA), .SelB(SelB), .WrAddr(WrAddr), .WrEn(WrEn), .Flags(Flags),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench ALU: FS[4]=1 add/subtract with carry; FS[4]=0 logic ops with an arbitrary Cout.
  function automatic logic [16:0] alu(input logic [4:0] fs, input logic [15:0] a,
                                      input logic [15:0] b, input logic cin);
    logic [16:0] r;
    r = '0;
    if (fs[4]) begin
      r = {1'b0, a} + {1'b0, (fs[0] ? ~b : b)} + {16'b0, cin};
    end else begin
      case (fs[1:0])
        2'd0:    r[15:0] = a & b;
        2'd1:    r[15:0] = a | b;
        2'd2:    r[15:0] = a ^ b;
        default: r[15:0] = a ^ b ^ {15'b0, cin};
      endcase
      r[16] = ~a[15];
    end
    return r;
  endfunction

  // Register file surrounding the DUT; presets go through the same clocked process.
  logic [15:0] rf [8];
  logic        pre_vld = 1'b0;
  logic [2:0]  pre_addr;
  logic [15:0] pre_dat;

  always_comb begin
    {Cout, F} = alu(FS, rf[SelA], rf[SelB], Cin);
  end

  always @(posedge Clock) begin
    if (WrEn)         rf[WrAddr]   <= F;
    else if (pre_vld) rf[pre_addr] <= pre_dat;
  end

  // Reference model state at instruction granularity.
  logic [15:0] mrf [8];
  logic        mc;
  logic [15:0] mcount;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] data;
    logic        cin;
    logic [2:0]  flags;
    logic [15:0] count;
  } exp_t;
  exp_t exp_q[$];

  task automatic model_issue(input logic [15:0] ins);
    logic [16:0] r;
    logic        cin;
    exp_t        e;
    cin = ins[1] ? mc : ins[0];
    r   = alu(ins[15:11], mrf[ins[7:5]], mrf[ins[4:2]], cin);
    if (ins[15]) mc = r[16];
    e.rd    = ins[10:8];
    e.data  = r[15:0];
    e.cin   = cin;
    e.flags = {mc, (r[15:0] == 16'h0000), r[15]};
    e.count = mcount;
    mrf[ins[10:8]] = r[15:0];
    mcount = mcount + 16'd1;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every write-back against the head of the scoreboard.
  logic cin_prev = 1'b0;
  logic wr_prev  = 1'b0;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  int   wr_pulses = 0;
  int   burst_n = 0;
  logic expect_gap3 = 1'b0;

  always @(negedge Clock) begin
    exp_t e;
    cyc++;
    if (Reset) begin
      wr_prev = 1'b0;
    end else begin
      if (WrEn) begin
        wr_pulses++;
        if (wr_prev) chk("wren_single_cycle", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_wren", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", WrAddr, e.rd);
          chk("wr_data", F, e.data);
          chk("exec_cin", cin_prev, e.cin);
          chk("flags", Flags, e.flags);
          chk("count_in_wb", InstrCount, e.count);
        end
        if (expect_gap3) begin
          if (burst_n > 0) chk("wren_gap", cyc - last_wr_cyc, 32'd3);
          burst_n++;
        end
        last_wr_cyc = cyc;
        chk("ready_in_wb", InstrReady, 1'b0);
      end
      wr_prev  = WrEn;
      cin_prev = Cin;
    end
  end

  task automatic set_reg(input logic [2:0] a, input logic [15:0] v);
    @(negedge Clock);
    pre_vld = 1'b1; pre_addr = a; pre_dat = v;
    mrf[a] = v;
    @(posedge Clock);
    #1 pre_vld = 1'b0;
  endtask

  // Presents ins and returns just after the accepting edge, leaving InstrValid high.
  task automatic send(input logic [15:0] ins);
    int n;
    n = 0;
    @(negedge Clock);
    InstrValid = 1'b1;
    Instr = ins;
    while (!InstrReady && n < 10) begin
      @(negedge Clock);
      n++;
    end
    if (!InstrReady) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      model_issue(ins);
      @(posedge Clock);
      #1 Instr = 16'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge Clock);
    while ((!InstrReady || exp_q.size() != 0) && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] v;
    v = 16'($urandom);
    if (v[15]) v[1] = 1'b0;  // arithmetic ops take a literal carry
    return v;
  endfunction

  logic [15:0] mrf_s [8];
  logic        mc_s;
  logic [15:0] mcount_s;
  int          base;

  initial begin
    Reset = 1'b1; InstrValid = 1'b0; Instr = 16'h0000;
    mc = 1'b0; mcount = 16'h0000;
    for (int i = 0; i < 8; i++) set_reg(3'(i), 16'($urandom));
    #1;
    chk("rst_ready", InstrReady, 1'b1);
    chk("rst_wren", WrEn, 1'b0);
    chk("rst_flags", Flags, 3'b000);
    chk("rst_count", InstrCount, 16'h0000);
    chk("rst_fields", {FS, Cin, SelA, SelB, WrAddr}, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;

    // Reset mid-EXEC aborts the instruction entirely.
    mrf_s = mrf; mc_s = mc; mcount_s = mcount;
    send({5'b10100, 3'd2, 3'd3, 3'd4, 1'b0, 1'b1});
    InstrValid = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    void'(exp_q.pop_back());
    mrf = mrf_s; mc = 1'b0; mcount = 16'h0000;
    #2;
    chk("abort_wren", WrEn, 1'b0);
    chk("abort_ready", InstrReady, 1'b1);
    chk("abort_fields", {FS, Cin, SelA, SelB, WrAddr}, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
    Instr = {5'b00001, 3'd0, 3'd6, 3'd7, 1'b0, 1'b0};
    InstrValid = 1'b1;
    model_issue(Instr);
    @(posedge Clock);
    #1 InstrValid = 1'b0;
    chk("abort_flags", Flags, 3'b000);
    chk("abort_count", InstrCount, 16'h0000);
    chk("accept_first_edge", InstrReady, 1'b0);
    wait_idle();

    // ADD with literal carry plus latency profile.
    set_reg(3'd1, 16'h0005);
    set_reg(3'd2, 16'h0003);
    send(16'b10100_011_001_010_0_1);
    InstrValid = 1'b0;
    @(negedge Clock);
    chk("lat_exec_wren", WrEn, 1'b0);
    chk("lat_exec_ready", InstrReady, 1'b0);
    chk("add_cin", Cin, 1'b1);
    @(negedge Clock);
    chk("lat_wb_wren", WrEn, 1'b1);
    chk("add_wraddr", WrAddr, 3'd3);
    chk("add_f", F, 16'h0009);
    @(negedge Clock);
    chk("lat_ready_again", InstrReady, 1'b1);
    chk("add_result", rf[3], 16'h0009);
    chk("add_flags", Flags, 3'b000);
    wait_idle();

    // Carry chain, then a logic op that consumes and preserves C.
    set_reg(3'd4, 16'hFFFF);
    set_reg(3'd5, 16'h0001);
    send({5'b10100, 3'd6, 3'd4, 3'd5, 1'b0, 1'b0});
    InstrValid = 1'b0;
    wait_idle();
    chk("carry_flags", Flags, 3'b110);
    set_reg(3'd1, 16'h8000);
    set_reg(3'd2, 16'hFFFF);
    send({5'b01000, 3'd7, 3'd1, 3'd2, 1'b1, 1'b0});
    InstrValid = 1'b0;
    @(negedge Clock);
    chk("cinsel_cin", Cin, 1'b1);
    wait_idle();
    chk("and_flags", Flags, 3'b101);
    chk("and_result", rf[7], 16'h8000);

    // Randomized instructions with occasional idle gaps.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        InstrValid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge Clock);
      end
      send(rand_instr());
    end
    InstrValid = 1'b0;
    wait_idle();
    chk("rand_count", InstrCount, mcount);

    // Back-to-back handshake from a fresh reset.
    @(negedge Clock);
    Reset = 1'b1;
    mc = 1'b0; mcount = 16'h0000;
    @(negedge Clock);
    Reset = 1'b0;
    base = wr_pulses;
    burst_n = 0;
    expect_gap3 = 1'b1;
    for (int k = 0; k < 4; k++) send(rand_instr());
    InstrValid = 1'b0;
    wait_idle();
    expect_gap3 = 1'b0;
    chk("burst_pulses", wr_pulses - base, 32'd4);
    chk("burst_count", InstrCount, 16'd4);

    // Counter wrap.
    @(negedge Clock);
    force dut.instr_count = 16'hFFFF;
    @(negedge Clock);
    release dut.instr_count;
    mcount = 16'hFFFF;
    chk("wrap_preset", InstrCount, 16'hFFFF);
    send(rand_instr());
    InstrValid = 1'b0;
    wait_idle();
    chk("wrap_zero", InstrCount, 16'h0000);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_control_unit.md
ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

Interface
REQ-001 SHALL have port Clock  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port InstrValid  input  1  upstream instruction present.
REQ-004 SHALL have port Instr  input  16  [15:11]=FS, [10:8]=Rd, [7:5]=Ra, [4:2]=Rb, [1]=CinSel, [0]=CinLit.
REQ-005 SHALL have port InstrReady  output  1  unit can accept an instruction this cycle.
REQ-006 SHALL have port F  input  16  ALU result, combinational from A/B/FS/Cin.
REQ-007 SHALL have port Cout  input  1  ALU carry out.
REQ-008 SHALL have port FS  output  5  ALU function select.
REQ-009 SHALL have port Cin  output  1  ALU carry in.
REQ-010 SHALL have ports SelA, SelB  output  3 each  register-file read addresses feeding ALU A and B.
REQ-011 SHALL have ports WrAddr  output  3  and WrEn  output  1  register-file write port control (data = F).
REQ-012 SHALL have port Flags  output  3  {C,Z,N}.
REQ-013 SHALL have port InstrCount  output  16  retired-instruction counter.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, WB; transitions IDLE->EXEC on InstrValid&InstrReady, EXEC->WB unconditionally, WB->IDLE unconditionally.
REQ-015 SHALL assert InstrReady only in IDLE; InstrValid outside IDLE is ignored, Instr not sampled.
REQ-016 SHALL capture Instr into internal IR on the accepting edge; IR held constant through EXEC and WB.
REQ-017 SHALL drive FS=IR[15:11], SelA=IR[7:5], SelB=IR[4:2], WrAddr=IR[10:8] from IR in all states.
REQ-018 SHALL drive Cin = Flags.C when IR[1]=1, else IR[0].
REQ-019 SHALL latch flags on the EXEC->WB edge: Z=(F==0), N=F[15], C=Cout only when IR[15]=1 (arithmetic/shift FS codes 10000-11111), C unchanged for FS[4]=0.
REQ-020 SHALL assert WrEn for exactly the one WB cycle per instruction, never in IDLE or EXEC.
REQ-021 SHALL increment InstrCount by 1 on the WB->IDLE edge, wrapping 16'hFFFF -> 16'h0000.
REQ-022 SHALL yield latency: instruction accepted at edge N -> WrEn high in cycle between edges N+1 and N+2 -> InstrReady high again after edge N+2; throughput one instruction per 3 cycles.
REQ-023 SHALL allow Rd equal to Ra or Rb; write occurs only in WB, so operands read in EXEC are pre-write values.
REQ-024 SHALL use Cin from Flags.C as held during EXEC (pre-update value), even when the same instruction updates C.

Reset
REQ-025 SHALL on Reset=1, independent of Clock, force state IDLE, IR=16'h0000, Flags=3'b000, InstrCount=0, WrEn=0.
REQ-026 SHALL therefore present during reset FS=5'b00000, Cin=0, SelA=SelB=WrAddr=0, InstrReady=1 as combinational consequences.
REQ-027 SHALL abort any in-flight instruction when Reset asserts in EXEC or WB: no WrEn, no flag update, no count increment.
REQ-028 SHALL accept a new instruction on the first rising edge after Reset deasserts if InstrValid=1.

Structure
REQ-029 SHALL place state encoding (IDLE/EXEC/WB), instruction field bit positions and the flag-index constants in shared package alu_ctrl_pkg.
REQ-030 SHALL use one sub-module, alu_flag_reg, holding C/Z/N with load-enable and C-update-enable inputs; FSM, IR and counter remain in the top.

Verification
REQ-031 SHALL verify reset: Reset pulsed mid-EXEC -> WrEn stays 0, Flags=000, InstrCount=0, InstrReady=1 on next cycle.
REQ-032 SHALL verify ADD: Instr=16'b10100_011_001_010_0_1 (FS=10100, Rd=3, Ra=1, Rb=2, CinLit=1), bench ALU model F=A+B+Cin with A=16'h0005, B=16'h0003 -> Cin=1, F=16'h0009, WrEn high one cycle with WrAddr=3, Flags=000.
REQ-033 SHALL verify carry chain: FS=10100, A=16'hFFFF, B=16'h0001, CinLit=0 -> Flags.C=1, Z=1; next instruction with CinSel=1 -> Cin=1.
REQ-034 SHALL verify logic op preserves C: after C=1, FS=01000 (AND) with F=16'h8000 -> C=1, Z=0, N=1.
REQ-035 SHALL verify handshake: InstrValid held high continuously for 4 instructions -> exactly 4 WrEn pulses, 3 cycles apart, InstrCount=4.
REQ-036 SHALL verify counter wrap: InstrCount preset via 65536 retired instructions (or force) -> 16'hFFFF then 16'h0000.
